// File: rtl/mips_mem_pkg.sv
// Shared types and defaults for the MIPS unified-memory arbiter.
package mips_mem_pkg;

  localparam int unsigned AW_DEF      = 32;
  localparam int unsigned DW_DEF      = 32;
  localparam int unsigned TIMEOUT_DEF = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic {
    GNT_IF = 1'b0,
    GNT_D  = 1'b1
  } grant_e;

endpackage

// File: rtl/mips_rr_arb2.sv
// Two-requester round-robin picker; remembers the last winner.
module mips_rr_arb2
  import mips_mem_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic req_if,
  input  logic req_d,
  input  logic en,
  output logic gnt_valid_c,
  output logic gnt_d_c
);

  grant_e last_grant_q;
  grant_e last_grant_d;
  grant_e gnt;

  always_comb begin
    gnt_valid_c  = req_if | req_d;
    gnt          = GNT_IF;
    last_grant_d = last_grant_q;
    // On contention the requester that did not win last time goes first
    if (req_if && req_d) begin
      gnt = (last_grant_q == GNT_D) ? GNT_IF : GNT_D;
    end else if (req_d) begin
      gnt = GNT_D;
    end
    if (en && gnt_valid_c) begin
      last_grant_d = gnt;
    end
    gnt_d_c = (gnt == GNT_D);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant_q <= GNT_D;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: rtl/mips_mem_arbiter.sv
// Arbitrates fetch and load/store requesters onto one single-port memory
// with a req/ack handshake, completion pulses and a sticky timeout flag.
module mips_mem_arbiter
  import mips_mem_pkg::*;
#(
  parameter int unsigned AW      = AW_DEF,
  parameter int unsigned DW      = DW_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_valid,
  output logic [DW-1:0] if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic          d_byte,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_valid,
  output logic [DW-1:0] d_rdata,
  output logic          mem_req,
  output logic          mem_we,
  output logic          mem_byte,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_rdata,
  output logic          stall,
  output logic          timeout_err
);

  localparam int unsigned CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  state_e        state_q,       state_d;
  logic [CW-1:0] cnt_q,         cnt_d;
  logic          gnt_d_q,       gnt_d_d;
  logic          mem_req_q,     mem_req_d;
  logic          mem_we_q,      mem_we_d;
  logic          mem_byte_q,    mem_byte_d;
  logic [AW-1:0] mem_addr_q,    mem_addr_d;
  logic [DW-1:0] mem_wdata_q,   mem_wdata_d;
  logic          if_valid_q,    if_valid_d;
  logic [DW-1:0] if_rdata_q,    if_rdata_d;
  logic          d_valid_q,     d_valid_d;
  logic [DW-1:0] d_rdata_q,     d_rdata_d;
  logic          timeout_err_q, timeout_err_d;

  logic          arb_en_c;
  logic          arb_valid_c;
  logic          arb_gnt_d_c;
  logic          finish_c;
  logic [DW-1:0] cap_c;

  assign arb_en_c = (state_q == IDLE);

  mips_rr_arb2 u_arb (
    .clk         (clk),
    .rst         (rst),
    .req_if      (if_req),
    .req_d       (d_req),
    .en          (arb_en_c),
    .gnt_valid_c (arb_valid_c),
    .gnt_d_c     (arb_gnt_d_c)
  );

  // Next-state and registered-output logic
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    gnt_d_d       = gnt_d_q;
    mem_req_d     = mem_req_q;
    mem_we_d      = mem_we_q;
    mem_byte_d    = mem_byte_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    if_valid_d    = 1'b0;
    if_rdata_d    = if_rdata_q;
    d_valid_d     = 1'b0;
    d_rdata_d     = d_rdata_q;
    timeout_err_d = timeout_err_q;
    finish_c      = 1'b0;
    cap_c         = '0;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (arb_valid_c) begin
          gnt_d_d   = arb_gnt_d_c;
          mem_req_d = 1'b1;
          state_d   = BUSY;
          if (arb_gnt_d_c) begin
            mem_we_d    = d_we;
            mem_byte_d  = d_byte;
            mem_addr_d  = d_addr;
            mem_wdata_d = d_wdata;
          end else begin
            mem_we_d    = 1'b0;
            mem_byte_d  = 1'b0;
            mem_addr_d  = if_addr;
            mem_wdata_d = '0;
          end
        end
      end

      BUSY: begin
        cnt_d = cnt_q + CW'(1);
        // An ack in the final allowed cycle beats the timeout
        if (mem_ack) begin
          finish_c = 1'b1;
          cap_c    = mem_we_q ? '0 : mem_rdata;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          finish_c      = 1'b1;
          timeout_err_d = 1'b1;
        end
        if (finish_c) begin
          cnt_d     = cnt_q;
          mem_req_d = 1'b0;
          state_d   = DONE;
          if (gnt_d_q) begin
            d_valid_d = 1'b1;
            d_rdata_d = cap_c;
          end else begin
            if_valid_d = 1'b1;
            if_rdata_d = cap_c;
          end
        end
      end

      DONE: begin
        cnt_d   = '0;
        state_d = IDLE;
      end

      default: begin
        cnt_d     = '0;
        mem_req_d = 1'b0;
        state_d   = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      gnt_d_q       <= 1'b0;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_byte_q    <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      if_valid_q    <= 1'b0;
      if_rdata_q    <= '0;
      d_valid_q     <= 1'b0;
      d_rdata_q     <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      gnt_d_q       <= gnt_d_d;
      mem_req_q     <= mem_req_d;
      mem_we_q      <= mem_we_d;
      mem_byte_q    <= mem_byte_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      if_valid_q    <= if_valid_d;
      if_rdata_q    <= if_rdata_d;
      d_valid_q     <= d_valid_d;
      d_rdata_q     <= d_rdata_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign if_valid    = if_valid_q;
  assign if_rdata    = if_rdata_q;
  assign d_valid     = d_valid_q;
  assign d_rdata     = d_rdata_q;
  assign mem_req     = mem_req_q;
  assign mem_we      = mem_we_q;
  assign mem_byte    = mem_byte_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign timeout_err = timeout_err_q;

  // The pipeline stalls while any requester is still waiting
  assign stall = (if_req & ~if_valid_q) | (d_req & ~d_valid_q);

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Scoreboard bench for mips_mem_arbiter with a delay-programmable memory model.
`timescale 1ns/1ps
module tb_mips_mem_arbiter;
  import mips_mem_pkg::*;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned TO = 4;
  localparam int NEVER = 1000;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic          if_valid;
  logic [DW-1:0] if_rdata;
  logic          d_req = 1'b0;
  logic          d_we = 1'b0;
  logic          d_byte = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic          d_valid;
  logic [DW-1:0] d_rdata;
  logic          mem_req, mem_we, mem_byte;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ack;
  logic [DW-1:0] mem_rdata = 32'hDEAD_BEEF;
  logic          stall, timeout_err;

  mips_mem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_valid(if_valid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_byte(d_byte), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_valid(d_valid), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_byte(mem_byte), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .stall(stall), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Scoreboard of expected completions
  typedef struct {
    bit          is_d;
    logic [31:0] data;
    int          cyc;
    string       name;
  } exp_t;
  exp_t sb[$];

  always @(negedge clk) begin
    if (rst && (if_valid || d_valid)) begin
      chk("valid_exclusive", 32'(if_valid & d_valid), 32'd0);
      chk("sb_has_entry", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        chk({e.name, "_port"}, 32'(d_valid), 32'(e.is_d));
        chk({e.name, "_rdata"}, d_valid ? d_rdata : if_rdata, e.data);
        if (e.cyc >= 0) chk({e.name, "_cycle"}, 32'(cyc), 32'(e.cyc));
      end
    end
  end

  // Memory model: acks ack_delay cycles after mem_req rises
  int          ack_delay = NEVER;
  logic [31:0] ack_q[$];
  logic        model_ack = 1'b0;
  logic        force_ack = 1'b0;
  int          mr_cnt = 0;
  int          req_len = 0;
  int          hold_err = 0;
  logic        cap_we, cap_byte;
  logic [31:0] cap_addr, cap_wdata;

  assign mem_ack = model_ack | force_ack;

  always @(negedge clk) begin
    if (mem_req) begin
      if (mr_cnt == 0) begin
        cap_we = mem_we; cap_byte = mem_byte; cap_addr = mem_addr; cap_wdata = mem_wdata;
      end else if ({mem_we, mem_byte, mem_addr, mem_wdata} !== {cap_we, cap_byte, cap_addr, cap_wdata}) begin
        hold_err++;
      end
      model_ack = 1'b0;
      mem_rdata = 32'hDEAD_BEEF;
      if (mr_cnt == ack_delay) begin
        model_ack = 1'b1;
        if (ack_q.size() != 0) mem_rdata = ack_q.pop_front();
      end
      mr_cnt++;
      req_len = mr_cnt;
    end else begin
      mr_cnt    = 0;
      model_ack = 1'b0;
      mem_rdata = 32'hDEAD_BEEF;
    end
  end

  task automatic do_fetch(input logic [31:0] a);
    if_addr = a;
    if_req  = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (if_valid) break;
    end
    chk("fetch_completed", 32'(if_valid), 32'd1);
    if_req = 1'b0;
  endtask

  task automatic do_data(input logic we, input logic byt, input logic [31:0] a,
                         input logic [31:0] wd, input bit chk_stall);
    int stall_bad;
    stall_bad = 0;
    d_we = we; d_byte = byt; d_addr = a; d_wdata = wd;
    d_req = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (d_valid) break;
      if (stall !== 1'b1) stall_bad++;
    end
    chk("data_completed", 32'(d_valid), 32'd1);
    if (chk_stall) begin
      chk("stall_high_until_d_valid", 32'(stall_bad), 32'd0);
      chk("stall_low_at_d_valid", 32'(stall), 32'd0);
    end
    d_req = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int c0;
    repeat (3) @(negedge clk);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_if_valid", 32'(if_valid), 32'd0);
    chk("rst_d_valid", 32'(d_valid), 32'd0);
    chk("rst_timeout_err", 32'(timeout_err), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_d_rdata", d_rdata, 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // A stray ack while idle must be ignored
    force_ack = 1'b1;
    @(negedge clk);
    force_ack = 1'b0;
    @(negedge clk);
    chk("stray_ack_mem_req", 32'(mem_req), 32'd0);

    // Reset asserted mid-BUSY discards the access, then the fetch is re-granted
    ack_delay = NEVER;
    if_addr = 32'h0000_0040;
    if_req  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (mem_req) break;
    end
    chk("rb_mem_req_up", 32'(mem_req), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rb_mem_req_drop", 32'(mem_req), 32'd0);
    chk("rb_if_valid", 32'(if_valid), 32'd0);
    chk("rb_state_idle", 32'(dut.state_q), 32'(IDLE));
    ack_delay = 1;
    ack_q.push_back(32'h1111_2222);
    sb.push_back('{1'b0, 32'h1111_2222, -1, "regrant"});
    @(negedge clk);
    rst = 1'b1;
    do_fetch(32'h0000_0040);
    chk("regrant_addr", cap_addr, 32'h0000_0040);

    // Single fetch, ack two cycles after mem_req
    repeat (2) @(negedge clk);
    hold_err  = 0;
    ack_delay = 2;
    ack_q.push_back(32'h2002_0005);
    sb.push_back('{1'b0, 32'h2002_0005, -1, "fetch"});
    do_fetch(32'h0000_0004);
    chk("fetch_mem_addr", cap_addr, 32'h0000_0004);
    chk("fetch_mem_we", 32'(cap_we), 32'd0);
    chk("fetch_mem_wdata", cap_wdata, 32'd0);
    chk("fetch_req_len", 32'(req_len), 32'd3);
    chk("fetch_hold", 32'(hold_err), 32'd0);

    // Contention from reset: fetch first, then load
    pulse_reset();
    ack_delay = 0;
    ack_q.push_back(32'hAAAA_0001);
    ack_q.push_back(32'hBBBB_0002);
    c0 = cyc;
    sb.push_back('{1'b0, 32'hAAAA_0001, c0 + 2, "cont_if"});
    sb.push_back('{1'b1, 32'hBBBB_0002, c0 + 5, "cont_d"});
    fork
      do_fetch(32'h0000_0008);
      do_data(1'b0, 1'b0, 32'h0000_0100, 32'd0, 1'b1);
    join
    chk("cont_load_addr", cap_addr, 32'h0000_0100);

    // Byte store: fields held, store returns zero
    repeat (2) @(negedge clk);
    hold_err  = 0;
    ack_delay = 1;
    ack_q.push_back(32'h5555_AAAA);
    sb.push_back('{1'b1, 32'd0, -1, "store"});
    do_data(1'b1, 1'b1, 32'h0000_0203, 32'h0000_00FF, 1'b0);
    chk("store_we", 32'(cap_we), 32'd1);
    chk("store_byte", 32'(cap_byte), 32'd1);
    chk("store_addr", cap_addr, 32'h0000_0203);
    chk("store_wdata", cap_wdata, 32'h0000_00FF);
    chk("store_hold", 32'(hold_err), 32'd0);

    // Ack in the last allowed BUSY cycle wins over timeout
    repeat (2) @(negedge clk);
    ack_delay = 3;
    ack_q.push_back(32'h1234_5678);
    sb.push_back('{1'b1, 32'h1234_5678, -1, "ack_last"});
    do_data(1'b0, 1'b0, 32'h0000_0300, 32'd0, 1'b0);
    chk("ack_last_req_len", 32'(req_len), 32'd4);
    chk("ack_last_no_timeout", 32'(timeout_err), 32'd0);
    repeat (3) @(negedge clk);
    chk("d_rdata_holds", d_rdata, 32'h1234_5678);

    // No ack ever: timeout after TO cycles of mem_req
    ack_delay = NEVER;
    sb.push_back('{1'b1, 32'd0, -1, "timeout"});
    do_data(1'b0, 1'b0, 32'h0000_0304, 32'd0, 1'b0);
    chk("timeout_req_len", 32'(req_len), 32'd4);
    chk("timeout_err_set", 32'(timeout_err), 32'd1);
    repeat (5) @(negedge clk);
    chk("timeout_err_sticky", 32'(timeout_err), 32'd1);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got 0x%08h expected 0x%08h", cyc, 0);
    $fatal(1, "bench did not finish");
  end

endmodule

// File: doc/mips_mem_arbiter.md
Name: mips_mem_arbiter

Overview:
Shares one single-port unified memory between the MIPS instruction-fetch requester and the load/store requester. It arbitrates between the two, latches the winning request, and drives a req/ack handshake to memory. It returns read data with a one-cycle valid pulse and flags memory timeouts. It sits between the datapath's fetch/data ports and the memory model, and converts the CPU to a stalled von Neumann configuration.

Parameters:
AW, 32, address width
DW, 32, data width
TIMEOUT, 64, max cycles waiting for mem_ack before abort (>=2)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low (0 = reset)
if_req  in  1  fetch request, level, held until if_valid
if_addr  in  AW  fetch address, stable while if_req
if_valid  out  1  one-cycle fetch completion pulse
if_rdata  out  DW  fetched word, valid with if_valid
d_req  in  1  data request, level, held until d_valid
d_we  in  1  1 = store, 0 = load
d_byte  in  1  byte access
d_addr  in  AW  data address
d_wdata  in  DW  store data
d_valid  out  1  one-cycle data completion pulse
d_rdata  out  DW  load data; 0 for stores
mem_req  out  1  memory request
mem_we  out  1  memory write enable
mem_byte  out  1  memory byte access
mem_addr  out  AW  memory address
mem_wdata  out  DW  memory write data
mem_ack  in  1  one-cycle completion from memory
mem_rdata  in  DW  read data, valid with mem_ack
stall  out  1  (if_req & ~if_valid) | (d_req & ~d_valid), combinational
timeout_err  out  1  sticky, set on any timeout

Behaviour:
- Reset (rst=0, async):
  - State is IDLE; last_grant=DATA, so fetch wins first.
  - All outputs are 0 and the timeout counter is 0.
  - mem_req drops immediately on reset assertion, and any in-flight access is discarded.
- FSM: IDLE -> BUSY -> DONE -> IDLE.
- IDLE:
  - Only one req high: grant it.
  - Both high: grant the requester not in last_grant (round-robin). Update last_grant.
  - On grant, register mem_we/mem_byte/mem_addr/mem_wdata from the winner. Fetch forces we=0, byte=0, wdata=0. Set mem_req=1 for the next cycle and go to BUSY.
  - No req: stay in IDLE with mem_req=0.
- BUSY:
  - mem_req and the mem_* fields are held constant.
  - The counter increments each cycle.
  - mem_ack=1: capture mem_rdata (write grant captures 0), drop mem_req next cycle, go to DONE.
  - Counter reaches TIMEOUT-1 with no ack: set timeout_err, capture 0, go to DONE.
  - Ack and timeout in the same cycle: ack wins and timeout_err is not set.
- DONE:
  - The granted requester's x_valid=1 for exactly this cycle, with x_rdata. The other requester's valid stays 0.
  - The counter clears.
  - No arbitration occurs in DONE, so a requester that keeps req high through its valid cycle is re-granted no earlier than IDLE.
  - Return to IDLE.
- Latency:
  - Request seen in IDLE at cycle 0.
  - mem_req=1 at cycles 1..k, with ack in cycle k.
  - valid in cycle k+1.
  - Minimum 3 cycles per access.
- if_rdata/d_rdata hold their last value between valid pulses.
- mem_ack outside BUSY is ignored.
- Requests dropped mid-access are still completed to memory; the valid pulse is issued anyway.
- timeout_err clears only on reset.
- Counter width: clog2(TIMEOUT). It never wraps because it clears in DONE.

Decomposition:
- Shared package mips_mem_pkg:
  - state enum {IDLE, BUSY, DONE}
  - grant enum {GNT_IF, GNT_D}
  - default AW/DW constants
- One natural sub-module: mips_rr_arb2, a 2-requester round-robin picker with a last_grant register. Everything else stays inline.

Test Plan:
- Reset mid-BUSY:
  - Stimulus: if_req=1, addr 0x0000_0040. Assert rst=0 while mem_req=1.
  - Required: mem_req=0 immediately, no if_valid, state IDLE, and after release the fetch is regranted.
- Single fetch:
  - Stimulus: if_req=1, addr 0x0000_0004. Memory acks 2 cycles after mem_req with 0x2002_0005.
  - Required: mem_addr=0x4, mem_we=0, if_valid pulses once with if_rdata=0x2002_0005, d_valid=0 throughout.
- Contention:
  - Stimulus: if_req and d_req high simultaneously from reset. The load is at 0x100; memory returns 0xAAAA_0001 for the fetch and 0xBBBB_0002 for the load, with immediate acks.
  - Required:
    - Fetch is granted first, then the load.
    - if_valid at cycle 3 with 0xAAAA_0001; d_valid at cycle 6 with 0xBBBB_0002.
    - stall stays 1 until d_valid.
- Store byte:
  - Stimulus: d_req=1, d_we=1, d_byte=1, addr 0x203, wdata 0x0000_00FF.
  - Required: mem_we=1, mem_byte=1, mem_addr=0x203, mem_wdata=0xFF held until ack; d_valid with d_rdata=0.
- Timeout:
  - Stimulus: TIMEOUT=4, load with no mem_ack ever.
  - Required: mem_req high for exactly 4 cycles, then d_valid with d_rdata=0, and timeout_err=1 stays set.
- Ack on last cycle:
  - Stimulus: TIMEOUT=4, mem_ack arrives in the 4th BUSY cycle with 0x1234_5678.
  - Required: d_rdata=0x1234_5678 and timeout_err stays 0.
